// File: rtl/stopwatch_core_pkg.sv
// Shared constants, state encoding and decode helpers for the mm:ss stopwatch.
package stopwatch_core_pkg;

  // Terminal value of both minutes and seconds, and the field width.
  localparam int MAX_VAL = 59;
  localparam int W       = 6;

  // Bit positions inside the blink_en field.
  localparam int BLINK_MIN = 0;
  localparam int BLINK_SEC = 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

  // Adjust mode overrides everything; otherwise the paused flag picks.
  function automatic state_e decode_state(input logic adj, input logic paused);
    if (adj) begin
      return ST_ADJUST;
    end
    if (paused) begin
      return ST_PAUSED;
    end
    return ST_RUN;
  endfunction

  // Only the field currently being adjusted blinks.
  function automatic logic [1:0] blink_for(input logic adj, input logic sel);
    logic [1:0] blink;
    blink = 2'b00;
    if (adj) begin
      if (sel) begin
        blink[BLINK_SEC] = 1'b1;
      end else begin
        blink[BLINK_MIN] = 1'b1;
      end
    end
    return blink;
  endfunction

endpackage

// File: rtl/stopwatch_core_mod_counter.sv
// Modulo counter: counts 0..term_i and wraps to 0; wrap_o flags the
// increment that wraps so a following stage can carry.
module mod_counter #(
  parameter int W = stopwatch_core_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Using >= means an out-of-range value still wraps on the next increment.
  assign wrap_o  = inc_i && (count_q >= term_i);
  assign count_o = count_q;

  // Next count: hold, increment, or wrap to zero.
  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    if (inc_i) begin
      count_d = wrap_o ? '0 : count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for state so all flops update together.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch time-keeping controller: run/pause/adjust control of a mm:ss
// counter pair, with registered blink enables and run status.
module stopwatch_core #(
  parameter int MAX_VAL = stopwatch_core_pkg::MAX_VAL,
  parameter int W       = stopwatch_core_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         count_tick,
  input  logic         adj_tick,
  input  logic         pause,
  input  logic         adj,
  input  logic         sel,
  output logic [W-1:0] min,
  output logic [W-1:0] sec,
  output logic [1:0]   blink_en,
  output logic         running
);

  import stopwatch_core_pkg::*;

  localparam logic [W-1:0] TERM = W'(MAX_VAL);

  logic       pause_q;
  logic       paused_q;
  logic       paused_d;
  logic       pause_rise;
  state_e     state_q;
  state_e     state_d;
  logic [1:0] blink_q;
  logic       running_q;

  logic       run_tick;
  logic       adj_sec_tick;
  logic       adj_min_tick;
  logic       sec_inc;
  logic       min_inc;
  logic       sec_wrap;
  logic       min_wrap;

  // A pause press toggles the paused flag in every state, including ADJUST.
  assign pause_rise = pause & ~pause_q;
  assign paused_d   = paused_q ^ pause_rise;
  assign state_d    = decode_state(adj, paused_d);

  // Ticks act under the registered state, so a tick coinciding with a pause
  // press or an adj change is applied under the old state.
  assign run_tick     = (state_q == ST_RUN) && count_tick;
  assign adj_sec_tick = (state_q == ST_ADJUST) && adj_tick && sel;
  assign adj_min_tick = (state_q == ST_ADJUST) && adj_tick && !sel;

  // Seconds carry into minutes only while running; adjust never carries.
  assign sec_inc = run_tick || adj_sec_tick;
  assign min_inc = (run_tick && sec_wrap) || adj_min_tick;

  mod_counter #(.W(W)) u_sec (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (sec_inc),
    .term_i  (TERM),
    .count_o (sec),
    .wrap_o  (sec_wrap)
  );

  mod_counter #(.W(W)) u_min (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (min_inc),
    .term_i  (TERM),
    .count_o (min),
    .wrap_o  (min_wrap)
  );

  // Control FSM: pause edge register, paused flag, mode state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_q   <= 1'b0;
      paused_q  <= 1'b0;
      state_q   <= decode_state(adj, 1'b0);
      blink_q   <= 2'b00;
      running_q <= 1'b1;
    end else begin
      pause_q   <= pause;
      paused_q  <= paused_d;
      state_q   <= state_d;
      blink_q   <= blink_for(adj, sel);
      running_q <= (state_d == ST_RUN);
    end
  end

  assign blink_en = blink_q;
  assign running  = running_q;

  // Minutes wrap needs no downstream consumer; 59:59 -> 00:00 falls out of
  // both counters wrapping on the same tick.
  logic unused_min_wrap;
  assign unused_min_wrap = min_wrap;

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Time-keeping controller for the mm:ss stopwatch.
- Sits between the debouncers and clock-enable generator (upstream) and the seven-segment display driver (downstream).
- Consumes the debounced pause/reset levels, the sel/adj switches and single-cycle tick enables.
- Produces registered minutes and seconds, a two-bit blink-enable field and a run status flag.
- All logic runs in the single system clock domain; tick enables replace derived clocks.

Parameters:
- MAX_VAL, 59, terminal value of both minutes and seconds; wraps to 0 after it.
- W, 6, width of the min/sec outputs; must hold MAX_VAL.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; debounced level.
- count_tick  input  1  one-cycle pulse at 1 Hz; advances time in run mode.
- adj_tick  input  1  one-cycle pulse at 2 Hz; advances the selected field in adjust mode.
- pause  input  1  debounced level; each rising edge toggles run/pause.
- adj  input  1  switch level; 1 = adjust mode.
- sel  input  1  switch level; 0 = minutes selected, 1 = seconds selected (adjust mode only).
- min  output  W  minutes, 0..MAX_VAL.
- sec  output  W  seconds, 0..MAX_VAL.
- blink_en  output  2  bit0 = blink minutes digits, bit1 = blink seconds digits.
- running  output  1  1 while counting in RUN state.

Behaviour:
- Reset (sync, highest priority):
  - min=0, sec=0, blink_en=2'b00, running=1.
  - paused flag=0, pause edge register=0.
  - State: RUN if adj=0, otherwise ADJUST.
- Pause edge detect: pause_q registers pause every cycle; pause_rise = pause & ~pause_q.
- paused flag toggles on every pause_rise, in any state, including ADJUST.
- States are decoded each cycle from adj and the paused flag:
  - ADJUST when adj=1.
  - PAUSED when adj=0 and paused=1.
  - RUN otherwise.
  - Changes on adj or the paused flag take effect from the cycle after they register.
- RUN, on count_tick:
  - sec<MAX_VAL: sec+1.
  - sec=MAX_VAL: sec=0 and min+1.
  - min=MAX_VAL with sec=MAX_VAL: both become 0 (59:59 -> 00:00).
- PAUSED: min and sec hold; count_tick is ignored.
- ADJUST:
  - count_tick is ignored.
  - On adj_tick, if sel=0: min increments, MAX_VAL wraps to 0, sec unchanged.
  - On adj_tick, if sel=1: sec increments, MAX_VAL wraps to 0, no carry into min.
- blink_en is registered, one-cycle latency from adj/sel:
  - 2'b01 in ADJUST with sel=0.
  - 2'b10 in ADJUST with sel=1.
  - 2'b00 otherwise.
- running is registered; 1 only in RUN.
- Latency: min/sec update on the clock edge that samples the tick; visible the next cycle.
- Simultaneous events:
  - A tick in the same cycle as pause_rise is applied under the old state. Example: RUN + count_tick + pause_rise counts once, then pauses.
  - A tick in the same cycle as an adj change is applied under the old state.
  - count_tick and adj_tick together: only the one valid for the current state acts.
  - reset with any tick: reset wins and no increment occurs.
- Leaving ADJUST restores RUN or PAUSED according to the paused flag; time values are kept.
- Values above MAX_VAL cannot occur; if forced, the next increment wraps to 0.

Decomposition:
- Shared package holds:
  - MAX_VAL and W constants.
  - Two-bit state encoding: RUN, PAUSED, ADJUST.
  - blink_en bit-index constants BLINK_MIN=0, BLINK_SEC=1.
- Natural sub-module mod_counter:
  - Inputs: clk, reset, inc enable, terminal value.
  - Outputs: count and a one-cycle wrap flag.
  - Two instances (sec, min). In RUN, the min increment enable is sec wrap AND count_tick.

Test Plan:
- Reset, then adj=0 and 61 count_ticks -> min=1, sec=1, running=1, blink_en=00.
- Preload 59:58 (adjust mode) and run 2 count_ticks -> 59:59 then 00:00.
- At 00:05 RUN, pulse pause (0->1->0) then 10 count_ticks -> stays 00:05, running=0. A second pause pulse plus 3 ticks -> 00:08.
- adj=1, sel=0, 3 adj_ticks from 00:00 -> 03:00, blink_en=01; count_ticks ignored. sel=1, 60 adj_ticks -> sec wraps to 00, min still 03, blink_en=10.
- count_tick coincident with pause_rise at 00:10 -> 00:11, then held. reset asserted together with count_tick at 12:34 -> 00:00 next cycle, running=1.
- Reset asserted mid-ADJUST (adj=1) -> 00:00, blink_en=01 or 10 per sel. Deassert adj -> RUN and counting resumes.
